// File: rtl/commit_retire_pkg.sv
// Shared by the in-order FIFO, dispatch and commit: entry field layout and the commit FSM encoding.
package commit_retire_pkg;

  // Flag bits in the low end of a FIFO entry; rd_phy starts at RDPHY_LSB and pc sits above it.
  localparam int unsigned EXC_BIT   = 0;
  localparam int unsigned ST_BIT    = 1;
  localparam int unsigned BR_BIT    = 2;
  localparam int unsigned RDEN_BIT  = 3;
  localparam int unsigned RDPHY_LSB = 4;
  localparam int unsigned FLAG_W    = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } cr_state_e;

endpackage

// File: rtl/commit_retire.sv
// In-order commit stage: pops the instruction FIFO head once its result is written back,
// releases rd, authorises stores, consumes branch results and raises aborts/traps.
module commit_retire
  import commit_retire_pkg::*;
#(
  parameter int unsigned PCW = 64,
  parameter int unsigned RNW = 6,
  parameter int unsigned IW  = PCW + RNW + FLAG_W
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                iOrder_vaild,
  output logic                commit_ready,
  input  logic [IW-1:0]       iOrder_info_pop,
  input  logic [2**RNW-1:0]   wb_op,
  input  logic                bru_res_vaild,
  output logic                bru_res_ready,
  input  logic                bru_mispredict,
  output logic                su_commit_vaild,
  input  logic                su_commit_ready,
  output logic                commit_rd_vaild,
  output logic [RNW-1:0]      commit_rd_phy,
  output logic                commit_abort,
  output logic                trap_vaild,
  output logic [PCW-1:0]      trap_epc,
  output logic [63:0]         retire_cnt
);

  cr_state_e state_q, state_d;

  logic [PCW-1:0] pc;
  logic [RNW-1:0] rd_phy;
  logic           rd_en, is_branch, is_store, is_except;
  logic           run, rd_ok, retirable, pop, retire, flush_req;

  assign pc        = iOrder_info_pop[IW-1:RNW+RDPHY_LSB];
  assign rd_phy    = iOrder_info_pop[RNW+RDPHY_LSB-1:RDPHY_LSB];
  assign rd_en     = iOrder_info_pop[RDEN_BIT];
  assign is_branch = iOrder_info_pop[BR_BIT];
  assign is_store  = iOrder_info_pop[ST_BIT];
  assign is_except = iOrder_info_pop[EXC_BIT];

  // RSTn gating keeps every handshake output low while reset is held.
  assign run   = RSTn && (state_q == RUN);
  assign rd_ok = !rd_en || wb_op[rd_phy];

  always_comb begin
    retirable = 1'b0;
    if (iOrder_vaild) begin
      if (is_except)
        retirable = 1'b1;
      else
        retirable = rd_ok && (!is_branch || bru_res_vaild) && (!is_store || su_commit_ready);
    end
  end

  assign commit_ready    = run && retirable;
  assign pop             = iOrder_vaild && commit_ready;
  assign retire          = pop && !is_except;
  assign bru_res_ready   = retire && is_branch;
  assign su_commit_vaild = run && iOrder_vaild && is_store && !is_except && rd_ok;
  assign flush_req       = pop && (is_except || (is_branch && bru_mispredict));

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush_req) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= RUN;
    else       state_q <= state_d;
  end

  // The FLUSH state itself is the registered abort pulse.
  assign commit_abort = (state_q == FLUSH);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      commit_rd_vaild <= 1'b0;
      commit_rd_phy   <= '0;
    end else begin
      commit_rd_vaild <= retire && rd_en;
      if (retire && rd_en) commit_rd_phy <= rd_phy;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      trap_vaild <= 1'b0;
      trap_epc   <= '0;
    end else begin
      trap_vaild <= pop && is_except;
      if (pop && is_except) trap_epc <= pc;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)       retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + 64'd1;
  end

endmodule
